// File: rtl/uart_tx_buffered.sv
// Byte-wide UART transmitter (8N1) fed by a power-of-two FIFO, with frame-boundary hold
// and a sticky overflow flag for writes attempted while the FIFO is full.
module uart_tx_buffered #(
  parameter int unsigned CLOCKS_PER_BAUD = 104,
  parameter int unsigned DEPTH_BITS      = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       write_i,
  input  logic [7:0] write_data_i,
  output logic       write_ready_o,
  input  logic       hold_i,
  output logic       tx_o,
  output logic       busy_o,
  output logic       overflow_o
);

  localparam int unsigned Depth = 2 ** DEPTH_BITS;
  localparam int unsigned BaudW = (CLOCKS_PER_BAUD > 1) ? $clog2(CLOCKS_PER_BAUD) : 1;
  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLOCKS_PER_BAUD - 1);
  localparam logic [DEPTH_BITS:0] Full = (DEPTH_BITS + 1)'(Depth);
  localparam logic [DEPTH_BITS:0] CountOne = (DEPTH_BITS + 1)'(1);
  localparam logic [DEPTH_BITS-1:0] PtrOne = DEPTH_BITS'(1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_t;

  state_t                state;
  logic [BaudW-1:0]      baud_cnt;
  logic [2:0]            bit_cnt;
  logic [7:0]            shift;
  logic [7:0]            mem [Depth];
  logic [DEPTH_BITS-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_BITS:0]   count, count_next;
  logic                  push, pop, baud_last, can_start;

  assign baud_last = (baud_cnt == BaudLast);
  assign can_start = (count != '0) && !hold_i;
  // Pops happen only where a new frame begins: from idle, or chained off the last stop cycle.
  assign pop       = can_start && ((state == StIdle) || ((state == StStop) && baud_last));
  assign push      = write_i && write_ready_o && !reset;
  assign busy_o    = (state != StIdle) || (count != '0);

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CountOne;
      2'b01:   count_next = count - CountOne;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= write_data_i;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      write_ready_o <= 1'b1;
      overflow_o    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PtrOne;
      if (pop)  rd_ptr <= rd_ptr + PtrOne;
      count         <= count_next;
      write_ready_o <= (count_next != Full);
      if (write_i && !write_ready_o) overflow_o <= 1'b1;
    end
  end

  // tx_o is registered from the current state, so the line lags the state by one cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= StIdle;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      tx_o     <= 1'b1;
    end else begin
      unique case (state)
        StIdle: begin
          tx_o <= 1'b1;
          if (pop) begin
            shift    <= mem[rd_ptr];
            baud_cnt <= '0;
            state    <= StStart;
          end
        end
        StStart: begin
          tx_o <= 1'b0;
          if (baud_last) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= StData;
          end else begin
            baud_cnt <= baud_cnt + BaudW'(1);
          end
        end
        StData: begin
          tx_o <= shift[0];
          if (baud_last) begin
            baud_cnt <= '0;
            shift    <= {1'b0, shift[7:1]};
            if (bit_cnt == 3'd7) state <= StStop;
            else bit_cnt <= bit_cnt + 3'd1;
          end else begin
            baud_cnt <= baud_cnt + BaudW'(1);
          end
        end
        StStop: begin
          tx_o <= 1'b1;
          if (baud_last) begin
            baud_cnt <= '0;
            if (pop) begin
              shift <= mem[rd_ptr];
              state <= StStart;
            end else begin
              state <= StIdle;
            end
          end else begin
            baud_cnt <= baud_cnt + BaudW'(1);
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
